// File: rtl/bk_pipe_adder.sv
// Three-stage pipelined Brent-Kung adder/subtractor with a global valid/ready stall.
// Define BK_PIPE_ADDER_OVF_EN to build the signed-overflow path; otherwise ovf is tied to 0.
`timescale 1ns/1ps
module bk_pipe_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int LOG = $clog2(WIDTH);

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    logic             v1, v2;
    logic [WIDTH-1:0] g1, p1;
    logic             c1;
    logic [WIDTH-1:0] g2, p2, pb2;
    logic             c2;

    logic [WIDTH-1:0] g_up, p_up;
    logic [WIDTH-1:0] g_dn, p_dn;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;

    assign advance = !out_valid || out_ready;
    // Masked during reset so nothing looks accepted on a cycle that is being discarded.
    assign in_ready = advance && !rst;
    assign b_eff    = sub ? ~y : y;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            g1  <= x & b_eff;
            p1  <= x ^ b_eff;
            c1  <= cin;
            g2  <= g_up;
            p2  <= p_up;
            pb2 <= p1;
            c2  <= c1;
        end
    end

    // Up-sweep: node i at level l absorbs the span ending 2^l bits below it.
    always_comb begin
        g_up = g1;
        p_up = p1;
        for (int l = 0; l < LOG; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 ** (l + 1))) == 0) begin
                    g_up[i] = g_up[i] | (p_up[i] & g_up[i - (2 ** l)]);
                    p_up[i] = p_up[i] & p_up[i - (2 ** l)];
                end
            end
        end
    end

    // Down-sweep fills the remaining prefixes; cin is applied afterwards through group propagate.
    always_comb begin
        g_dn = g2;
        p_dn = p2;
        for (int l = LOG - 2; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= 3 * (2 ** l) - 1) && (((i + 1) % (2 ** (l + 1))) == (2 ** l))) begin
                    g_dn[i] = g_dn[i] | (p_dn[i] & g_dn[i - (2 ** l)]);
                    p_dn[i] = p_dn[i] & p_dn[i - (2 ** l)];
                end
            end
        end
    end

    assign carry = {g_dn | (p_dn & {WIDTH{c2}}), c2};
    assign sum_d = pb2 ^ carry[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else if (advance) begin
            s    <= sum_d;
            cout <= carry[WIDTH];
        end
    end

`ifdef BK_PIPE_ADDER_OVF_EN
    logic a_msb1, b_msb1, a_msb2, b_msb2;

    always_ff @(posedge clk) begin
        if (advance) begin
            a_msb1 <= x[WIDTH-1];
            b_msb1 <= b_eff[WIDTH-1];
            a_msb2 <= a_msb1;
            b_msb2 <= b_msb1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= (a_msb2 == b_msb2) && (sum_d[WIDTH-1] != a_msb2);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
